// File: rtl/cmplx_nco_mixer.sv
// cmplx_nco_mixer: time-interleaved complex mixer, one NCO (phase acc + cos/sin LUT) per channel.
// Ports: iclk, ireset (async, active-high), iclkena; ival/isop/idat_re/idat_im sample in;
//   iphase_clr clears NCOs; iwr/iwaddr/iwdat write a frequency word;
//   oval/ochan/odat_re/odat_im out, 4 enabled clocks after ival.
// Define CMPLX_NCO_MIXER_SAT_EN to saturate the output; otherwise it wraps.
// LUT contents are elaborated from round(A*cos/sin(2*pi*k/2^pLUT_AW)).
module cmplx_nco_mixer #(
  parameter int pCHAN_NUM  = 4,
  parameter int pIDAT_W    = 16,
  parameter int pDDS_W     = 16,
  parameter int pODAT_W    = 18,
  parameter int pPHASE_W   = 32,
  parameter int pLUT_AW    = 10,
  parameter int pSHIFT     = 15,
  parameter int pCONJ      = 0,
  parameter int pUSE_ROUND = 0,
  localparam int CH_W = (pCHAN_NUM > 1) ? $clog2(pCHAN_NUM) : 1
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      iclkena,
  input  logic                      ival,
  input  logic                      isop,
  input  logic signed [pIDAT_W-1:0] idat_re,
  input  logic signed [pIDAT_W-1:0] idat_im,
  input  logic                      iphase_clr,
  input  logic                      iwr,
  input  logic [CH_W-1:0]           iwaddr,
  input  logic [pPHASE_W-1:0]       iwdat,
  output logic                      oval,
  output logic [CH_W-1:0]           ochan,
  output logic signed [pODAT_W-1:0] odat_re,
  output logic signed [pODAT_W-1:0] odat_im
);

  localparam int LUT_N = 2 ** pLUT_AW;
  localparam int PW    = pIDAT_W + pDDS_W;
  localparam int RW    = PW + 2;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(pCHAN_NUM - 1);
  localparam logic signed [RW-1:0] BIAS =
    (pUSE_ROUND != 0) ? (RW'(1) <<< (pSHIFT - 1)) : '0;
  localparam logic signed [RW-1:0] OMAX =
    {{(RW-pODAT_W+1){1'b0}}, {(pODAT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  typedef logic signed [pIDAT_W-1:0] dat_t;
  typedef logic signed [pDDS_W-1:0]  dds_t;
  typedef logic signed [PW-1:0]      prod_t;
  typedef logic [pPHASE_W-1:0]       ph_t;

  function automatic dds_t lut_val(input int k, input bit is_sin);
    real amp, th, v;
    int  iv;
    amp = real'((2 ** (pDDS_W - 1)) - 1);
    th  = 6.283185307179586 * real'(k) / real'(LUT_N);
    v   = is_sin ? amp * $sin(th) : amp * $cos(th);
    iv  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return dds_t'(iv);
  endfunction

  dds_t cos_rom [LUT_N];
  dds_t sin_rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam dds_t C = lut_val(k, 1'b0);
    localparam dds_t S = lut_val(k, 1'b1);
    assign cos_rom[k] = C;
    assign sin_rom[k] = S;
  end

  logic [CH_W-1:0]    cnt_q, cnt_d;
  ph_t                acc_q [pCHAN_NUM];
  ph_t                acc_d [pCHAN_NUM];
  ph_t                frq_q [pCHAN_NUM];
  ph_t                frq_d [pCHAN_NUM];

  logic               s1_val_q, s1_val_d;
  logic [CH_W-1:0]    s1_ch_q, s1_ch_d;
  dat_t               s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic [pLUT_AW-1:0] s1_addr_q, s1_addr_d;

  logic               s2_val_q, s2_val_d;
  logic [CH_W-1:0]    s2_ch_q, s2_ch_d;
  dat_t               s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  dds_t               s2_cos_q, s2_cos_d, s2_sin_q, s2_sin_d;

  logic               s3_val_q, s3_val_d;
  logic [CH_W-1:0]    s3_ch_q, s3_ch_d;
  prod_t              s3_rc_q, s3_rc_d, s3_is_q, s3_is_d;
  prod_t              s3_rs_q, s3_rs_d, s3_ic_q, s3_ic_d;

  logic               oval_q, oval_d;
  logic [CH_W-1:0]    ochan_q, ochan_d;
  logic [pODAT_W-1:0] ore_q, ore_d, oim_q, oim_d;

  logic [CH_W-1:0]    ch;
  ph_t                ph;
  logic               unused_ph;

  // A phase clear forces the current sample onto channel 0 at phase 0,
  // and its accumulator restarts from zero plus one frequency step.
  always_comb begin
    ch = (isop || iphase_clr) ? '0 : cnt_q;
    ph = '0;
    for (int c = 0; c < pCHAN_NUM; c++)
      if (ch == CH_W'(c)) ph = acc_q[c];
    if (iphase_clr) ph = '0;

    cnt_d = cnt_q;
    if (ival)
      cnt_d = (ch == LAST_CH) ? '0 : ch + 1'b1;
    else if (iphase_clr)
      cnt_d = '0;

    for (int c = 0; c < pCHAN_NUM; c++) begin
      acc_d[c] = iphase_clr ? '0 : acc_q[c];
      frq_d[c] = frq_q[c];
      if (ival && ch == CH_W'(c)) acc_d[c] = acc_d[c] + frq_q[c];
      if (iwr && iwaddr == CH_W'(c)) frq_d[c] = iwdat;
    end

    s1_val_d  = ival;
    s1_ch_d   = ch;
    s1_re_d   = idat_re;
    s1_im_d   = idat_im;
    s1_addr_d = ph[pPHASE_W-1 -: pLUT_AW];
  end

  assign unused_ph = ^ph;

  always_comb begin
    s2_val_d = s1_val_q;
    s2_ch_d  = s1_ch_q;
    s2_re_d  = s1_re_q;
    s2_im_d  = s1_im_q;
    s2_cos_d = cos_rom[s1_addr_q];
    s2_sin_d = sin_rom[s1_addr_q];

    s3_val_d = s2_val_q;
    s3_ch_d  = s2_ch_q;
    s3_rc_d  = prod_t'(s2_re_q) * prod_t'(s2_cos_q);
    s3_is_d  = prod_t'(s2_im_q) * prod_t'(s2_sin_q);
    s3_rs_d  = prod_t'(s2_re_q) * prod_t'(s2_sin_q);
    s3_ic_d  = prod_t'(s2_im_q) * prod_t'(s2_cos_q);
  end

  logic signed [RW-1:0] re_s, im_s, re_sh, im_sh;
  logic [pODAT_W-1:0]   re_o, im_o;

  always_comb begin
    if (pCONJ != 0) begin
      re_s = RW'(s3_rc_q) + RW'(s3_is_q) + BIAS;
      im_s = RW'(s3_ic_q) - RW'(s3_rs_q) + BIAS;
    end else begin
      re_s = RW'(s3_rc_q) - RW'(s3_is_q) + BIAS;
      im_s = RW'(s3_rs_q) + RW'(s3_ic_q) + BIAS;
    end
    re_sh = re_s >>> pSHIFT;
    im_sh = im_s >>> pSHIFT;
`ifdef CMPLX_NCO_MIXER_SAT_EN
    if (re_sh > OMAX)      re_o = OMAX[pODAT_W-1:0];
    else if (re_sh < OMIN) re_o = OMIN[pODAT_W-1:0];
    else                   re_o = re_sh[pODAT_W-1:0];
    if (im_sh > OMAX)      im_o = OMAX[pODAT_W-1:0];
    else if (im_sh < OMIN) im_o = OMIN[pODAT_W-1:0];
    else                   im_o = im_sh[pODAT_W-1:0];
`else
    re_o = re_sh[pODAT_W-1:0];
    im_o = im_sh[pODAT_W-1:0];
`endif
    oval_d  = s3_val_q;
    ochan_d = s3_val_q ? s3_ch_q : ochan_q;
    ore_d   = s3_val_q ? re_o : ore_q;
    oim_d   = s3_val_q ? im_o : oim_q;
  end

`ifndef CMPLX_NCO_MIXER_SAT_EN
  logic unused_hi;
  assign unused_hi = ^{re_sh, im_sh};
`endif

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      cnt_q <= '0;
      for (int c = 0; c < pCHAN_NUM; c++) begin
        acc_q[c] <= '0;
        frq_q[c] <= '0;
      end
      s1_val_q  <= 1'b0;
      s1_ch_q   <= '0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_addr_q <= '0;
      s2_val_q  <= 1'b0;
      s2_ch_q   <= '0;
      s2_re_q   <= '0;
      s2_im_q   <= '0;
      s2_cos_q  <= '0;
      s2_sin_q  <= '0;
      s3_val_q  <= 1'b0;
      s3_ch_q   <= '0;
      s3_rc_q   <= '0;
      s3_is_q   <= '0;
      s3_rs_q   <= '0;
      s3_ic_q   <= '0;
      oval_q    <= 1'b0;
      ochan_q   <= '0;
      ore_q     <= '0;
      oim_q     <= '0;
    end else if (iclkena) begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      frq_q     <= frq_d;
      s1_val_q  <= s1_val_d;
      s1_ch_q   <= s1_ch_d;
      s1_re_q   <= s1_re_d;
      s1_im_q   <= s1_im_d;
      s1_addr_q <= s1_addr_d;
      s2_val_q  <= s2_val_d;
      s2_ch_q   <= s2_ch_d;
      s2_re_q   <= s2_re_d;
      s2_im_q   <= s2_im_d;
      s2_cos_q  <= s2_cos_d;
      s2_sin_q  <= s2_sin_d;
      s3_val_q  <= s3_val_d;
      s3_ch_q   <= s3_ch_d;
      s3_rc_q   <= s3_rc_d;
      s3_is_q   <= s3_is_d;
      s3_rs_q   <= s3_rs_d;
      s3_ic_q   <= s3_ic_d;
      oval_q    <= oval_d;
      ochan_q   <= ochan_d;
      ore_q     <= ore_d;
      oim_q     <= oim_d;
    end
  end

  assign oval    = oval_q;
  assign ochan   = ochan_q;
  assign odat_re = ore_q;
  assign odat_im = oim_q;

endmodule

// File: tb/tb_cmplx_nco_mixer.sv
// tb_cmplx_nco_mixer: directed vectors for cmplx_nco_mixer.
// Four variants share inputs: default, rounding, conjugate, 16-bit output.
module tb_cmplx_nco_mixer;

  logic clk = 1'b0;
  logic rst, en, ival, isop, clr, iwr;
  logic [1:0] waddr;
  logic [31:0] wdat;
  logic signed [15:0] dre, dim;
  logic d_val, r_val, c_val, s_val;
  logic [1:0] d_ch, r_ch, c_ch, s_ch;
  logic signed [17:0] d_re, d_im, r_re, r_im, c_re, c_im;
  logic signed [15:0] s_re, s_im;
  int n_vec = 0;
  int n_err = 0;

`ifdef CMPLX_NCO_MIXER_SAT_EN
  localparam int SAT_RE = 32767;
`else
  localparam int SAT_RE = -19197;
`endif

  typedef struct {
    bit v; bit all; int ch;
    int re; int im; int rre; int rim;
    int cre; int cim; int sre; int sim;
  } exp_t;

  exp_t pipe [4];
  exp_t cur, last, zero_e;

  int q_dre [4] = '{739, -740, -740, 739};
  int q_dim [4] = '{739, 739, -740, -740};
  int q_rre [4] = '{740, -740, -740, 740};
  int q_rim [4] = '{740, 740, -740, -740};
  int q_cre [4] = '{739, 739, -740, -740};
  int q_cim [4] = '{739, -740, -740, 739};

  always #5 clk = ~clk;

  cmplx_nco_mixer dut (
    .iclk(clk), .ireset(rst), .iclkena(en), .ival(ival), .isop(isop),
    .idat_re(dre), .idat_im(dim), .iphase_clr(clr), .iwr(iwr),
    .iwaddr(waddr), .iwdat(wdat), .oval(d_val), .ochan(d_ch),
    .odat_re(d_re), .odat_im(d_im));

  cmplx_nco_mixer #(.pUSE_ROUND(1)) dut_r (
    .iclk(clk), .ireset(rst), .iclkena(en), .ival(ival), .isop(isop),
    .idat_re(dre), .idat_im(dim), .iphase_clr(clr), .iwr(iwr),
    .iwaddr(waddr), .iwdat(wdat), .oval(r_val), .ochan(r_ch),
    .odat_re(r_re), .odat_im(r_im));

  cmplx_nco_mixer #(.pCONJ(1)) dut_c (
    .iclk(clk), .ireset(rst), .iclkena(en), .ival(ival), .isop(isop),
    .idat_re(dre), .idat_im(dim), .iphase_clr(clr), .iwr(iwr),
    .iwaddr(waddr), .iwdat(wdat), .oval(c_val), .ochan(c_ch),
    .odat_re(c_re), .odat_im(c_im));

  cmplx_nco_mixer #(.pODAT_W(16)) dut_s (
    .iclk(clk), .ireset(rst), .iclkena(en), .ival(ival), .isop(isop),
    .idat_re(dre), .idat_im(dim), .iphase_clr(clr), .iwr(iwr),
    .iwaddr(waddr), .iwdat(wdat), .oval(s_val), .ochan(s_ch),
    .odat_re(s_re), .odat_im(s_im));

  function automatic exp_t mk(bit v, bit all, int ch, int re, int im,
                              int rre, int rim, int cre, int cim,
                              int sre, int sim);
    exp_t e;
    e.v = v; e.all = all; e.ch = ch; e.re = re; e.im = im;
    e.rre = rre; e.rim = rim; e.cre = cre; e.cim = cim;
    e.sre = sre; e.sim = sim;
    return e;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic check_out();
    chk("oval", 64'(d_val), 64'(pipe[3].v));
    if (pipe[3].v) last = pipe[3];
    chk("ochan", 64'(d_ch), 64'(last.ch));
    chk("re", 64'(d_re), 64'(last.re));
    chk("im", 64'(d_im), 64'(last.im));
    if (pipe[3].v && pipe[3].all) begin
      chk("r_oval", 64'(r_val), 64'(1));
      chk("r_re", 64'(r_re), 64'(pipe[3].rre));
      chk("r_im", 64'(r_im), 64'(pipe[3].rim));
      chk("c_ch", 64'(c_ch), 64'(pipe[3].ch));
      chk("c_re", 64'(c_re), 64'(pipe[3].cre));
      chk("c_im", 64'(c_im), 64'(pipe[3].cim));
      chk("s_ch", 64'(s_ch), 64'(pipe[3].ch));
      chk("s_re", 64'(s_re), 64'(pipe[3].sre));
      chk("s_im", 64'(s_im), 64'(pipe[3].sim));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (en) begin
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = cur;
    end
    cur = zero_e;
    ival = 1'b0; isop = 1'b0; clr = 1'b0; iwr = 1'b0;
    check_out();
  endtask

  task automatic smp(input bit sop, input int a, input int b,
                     input int ch, input int ere, input int eim);
    ival = 1'b1; isop = sop; dre = 16'(a); dim = 16'(b);
    cur = mk(1'b1, 1'b0, ch, ere, eim, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic smp4(input bit sop, input int a, input int b, input int ch,
                      input int e0, input int e1, input int e2, input int e3,
                      input int e4, input int e5, input int e6, input int e7);
    ival = 1'b1; isop = sop; dre = 16'(a); dim = 16'(b);
    cur = mk(1'b1, 1'b1, ch, e0, e1, e2, e3, e4, e5, e6, e7);
    tick();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) pipe[i] = zero_e;
    cur = zero_e;
    last = zero_e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; ival = 1'b0; isop = 1'b0; clr = 1'b0;
    iwr = 1'b0; waddr = 2'd0; wdat = 32'd0; dre = '0; dim = '0;
    zero_e = mk(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oval", 64'(d_val), 64'(0));
    chk("rst_ochan", 64'(d_ch), 64'(0));
    chk("rst_re", 64'(d_re), 64'(0));
    chk("rst_im", 64'(d_im), 64'(0));
    chk("rst_r_oval", 64'(r_val), 64'(0));
    chk("rst_c_oval", 64'(c_val), 64'(0));
    chk("rst_s_oval", 64'(s_val), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      smp4(i == 0, 740, 740, i % 4,
           739, 739, 740, 740, 739, 739, 739, 739);
    repeat (4) tick();

    iwr = 1'b1; waddr = 2'd1; wdat = 32'h4000_0000;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 1)
        smp4(1'b0, 740, 740, 1,
             q_dre[i/4], q_dim[i/4], q_rre[i/4], q_rim[i/4],
             q_cre[i/4], q_cim[i/4], q_dre[i/4], q_dim[i/4]);
      else
        smp4(i == 0, 740, 740, i % 4,
             739, 739, 740, 740, 739, 739, 739, 739);
    end
    repeat (4) tick();

    clr = 1'b1; iwr = 1'b1; waddr = 2'd2; wdat = 32'h2000_0000;
    tick();
    smp4(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    smp4(1'b0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    smp4(1'b0, -32768, -32768, 2, -32767, -32767, -32767, -32767,
         -32767, -32767, -32767, -32767);
    smp4(1'b0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    smp4(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    smp4(1'b0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    smp4(1'b0, 32767, -32768, 2, 46339, -1, 46339, -1,
         -1, -46340, SAT_RE, -1);
    repeat (4) tick();

    clr = 1'b1; iwr = 1'b1; waddr = 2'd0; wdat = 32'h4000_0000;
    tick();
    smp(1'b1, 740, 740, 0, 739, 739);
    smp(1'b0, 740, 740, 1, 739, 739);
    smp(1'b0, 740, 740, 2, 739, 739);
    clr = 1'b1;
    smp(1'b0, 740, 740, 0, 739, 739);
    iwr = 1'b1; waddr = 2'd1; wdat = 32'h8000_0000;
    smp(1'b0, 740, 740, 1, 739, 739);
    smp(1'b0, 740, 740, 2, 739, 739);
    smp(1'b0, 740, 740, 3, 739, 739);
    smp(1'b0, 740, 740, 0, -740, 739);
    smp(1'b0, 740, 740, 1, -740, 739);
    smp(1'b0, 740, 740, 2, 0, 1046);
    repeat (4) tick();

    clr = 1'b1;
    tick();
    smp(1'b1, 740, 740, 0, 739, 739);
    smp(1'b0, 740, 740, 1, 739, 739);
    smp(1'b0, 740, 740, 2, 739, 739);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ival = 1'b1; isop = 1'b1; clr = 1'b1; iwr = 1'b1;
      waddr = 2'd3; wdat = 32'h4000_0000; dre = 16'sd100; dim = -16'sd100;
      tick();
    end
    en = 1'b1;
    smp(1'b0, 740, 740, 3, 739, 739);
    smp(1'b0, 740, 740, 0, -740, 739);
    smp(1'b0, 740, 740, 1, -740, -740);
    smp(1'b0, 740, 740, 2, 0, 1046);
    smp(1'b0, 740, 740, 3, 739, 739);
    repeat (4) tick();

    clr = 1'b1;
    tick();
    for (int i = 0; i < 4; i++)
      smp(i == 0, 740, 740, i, 739, 739);
    #2 rst = 1'b1;
    #1;
    chk("arst_oval", 64'(d_val), 64'(0));
    chk("arst_ochan", 64'(d_ch), 64'(0));
    chk("arst_re", 64'(d_re), 64'(0));
    chk("arst_im", 64'(d_im), 64'(0));
    chk("arst_s_oval", 64'(s_val), 64'(0));
    #1 rst = 1'b0;
    clear_model();
    repeat (5) tick();
    smp(1'b1, 740, 740, 0, 739, 739);
    smp(1'b0, 740, 740, 1, 739, 739);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
